// File: rtl/reprog_session_ctrl_if.sv
// Byte-stream and status bundle between the UART front end, the RAM
// reprogramming port and the session controller.
interface reprog_session_ctrl_if;
    logic [7:0] rxData;
    logic       rxValid;
    logic       progEn;
    logic [7:0] progData;
    logic       progValid;
    logic       cpuHold;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] errCode;

    // Side that supplies bytes and observes the session.
    modport master (
        output rxData, rxValid,
        input  progEn, progData, progValid, cpuHold, busy, done, error, errCode
    );

    // Session controller side.
    modport slave (
        input  rxData, rxValid,
        output progEn, progData, progValid, cpuHold, busy, done, error, errCode
    );
endinterface

// File: rtl/reprog_session_ctrl.sv
// UART-driven RAM reprogramming session sequencer: parses a framed byte
// stream (sync, 32-bit word count, payload, checksum), forwards payload
// bytes to the reprogramming port and holds the CPU in reset meanwhile.
module reprog_session_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter logic [7:0]  SYNC0      = 8'h55,
    parameter logic [7:0]  SYNC1      = 8'hAA
) (
    input  logic                 clk,
    input  logic                 rstn,
    reprog_session_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = ADDR_WIDTH + 3;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] LEN   = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] CSUM  = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [2:0] ERR   = 3'd7;

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    logic [2:0]        state,      stateNext;
    logic [CNT_W-1:0]  byteCnt,    byteCntNext;
    logic [CNT_W-1:0]  byteTarget, byteTargetNext;
    logic [31:0]       lenReg,     lenRegNext;
    logic [7:0]        csum,       csumNext;
    logic [IDLE_W-1:0] idleCnt,    idleCntNext;
    logic              drainCnt,   drainCntNext;
    logic              progEn,     progEnNext;
    logic [7:0]        progData,   progDataNext;
    logic              progValid,  progValidNext;
    logic              cpuHold,    cpuHoldNext;
    logic              busy,       busyNext;
    logic              done,       doneNext;
    logic              error,      errorNext;
    logic [1:0]        errCode,    errCodeNext;

    logic              timedState;
    logic              timedOut;
    logic [31:0]       lenFull;

    // Timeout only watches states that are waiting for the next frame byte.
    always_comb begin
        timedState = (state == SYNC) || (state == LEN) || (state == DATA) || (state == CSUM);
        timedOut   = timedState && (idleCnt == IDLE_W'(TIMEOUT));
        lenFull    = {bus.rxData, lenReg[31:8]};
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        stateNext      = state;
        byteCntNext    = byteCnt;
        byteTargetNext = byteTarget;
        lenRegNext     = lenReg;
        csumNext       = csum;
        idleCntNext    = '0;
        drainCntNext   = drainCnt;
        progEnNext     = progEn;
        progDataNext   = progData;
        progValidNext  = 1'b0;
        cpuHoldNext    = cpuHold;
        doneNext       = done;
        errorNext      = error;
        errCodeNext    = errCode;

        if (timedState && !timedOut && !bus.rxValid) begin
            idleCntNext = idleCnt + IDLE_W'(1);
        end

        case (state)
            IDLE: begin
                if (bus.rxValid && bus.rxData == SYNC0) begin
                    stateNext = SYNC;
                end
            end
            SYNC: begin
                // A stalled sync is not a session yet, so it just drops back.
                if (timedOut) begin
                    stateNext = IDLE;
                end else if (bus.rxValid) begin
                    if (bus.rxData == SYNC1) begin
                        stateNext   = LEN;
                        byteCntNext = '0;
                        lenRegNext  = '0;
                        csumNext    = '0;
                        progEnNext  = 1'b1;
                        cpuHoldNext = 1'b1;
                        doneNext    = 1'b0;
                        errorNext   = 1'b0;
                        errCodeNext = 2'd0;
                    end else if (bus.rxData != SYNC0) begin
                        stateNext = IDLE;
                    end
                end
            end
            LEN: begin
                if (timedOut) begin
                    stateNext   = ERR;
                    errCodeNext = ERR_TIMEOUT;
                    progEnNext  = 1'b0;
                end else if (bus.rxValid) begin
                    lenRegNext  = lenFull;
                    byteCntNext = byteCnt + CNT_W'(1);
                    if (byteCnt[1:0] == 2'd3) begin
                        byteCntNext = '0;
                        if ({1'b0, lenFull} > MAX_WORDS) begin
                            stateNext   = ERR;
                            errCodeNext = ERR_LEN;
                            progEnNext  = 1'b0;
                        end else if (lenFull == 32'd0) begin
                            stateNext = CSUM;
                        end else begin
                            stateNext      = DATA;
                            byteTargetNext = CNT_W'({lenFull, 2'b00});
                        end
                    end
                end
            end
            DATA: begin
                // Leave only once the last strobe has gone out, so progValid
                // never appears outside DATA; a checksum byte arriving right
                // then is evaluated here.
                if (timedOut) begin
                    stateNext   = ERR;
                    errCodeNext = ERR_TIMEOUT;
                    progEnNext  = 1'b0;
                end else if (byteCnt == byteTarget) begin
                    if (!bus.rxValid) begin
                        stateNext = CSUM;
                    end else if (bus.rxData == csum) begin
                        stateNext    = DRAIN;
                        drainCntNext = 1'b0;
                    end else begin
                        stateNext   = ERR;
                        errCodeNext = ERR_CSUM;
                        progEnNext  = 1'b0;
                    end
                end else if (bus.rxValid) begin
                    progDataNext  = bus.rxData;
                    progValidNext = 1'b1;
                    csumNext      = csum + bus.rxData;
                    byteCntNext   = byteCnt + CNT_W'(1);
                end
            end
            CSUM: begin
                if (timedOut) begin
                    stateNext   = ERR;
                    errCodeNext = ERR_TIMEOUT;
                    progEnNext  = 1'b0;
                end else if (bus.rxValid) begin
                    if (bus.rxData == csum) begin
                        stateNext    = DRAIN;
                        drainCntNext = 1'b0;
                    end else begin
                        stateNext   = ERR;
                        errCodeNext = ERR_CSUM;
                        progEnNext  = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (drainCnt) begin
                    stateNext  = DONE;
                    progEnNext = 1'b0;
                end else begin
                    drainCntNext = 1'b1;
                end
            end
            DONE: begin
                doneNext    = 1'b1;
                errorNext   = 1'b0;
                cpuHoldNext = 1'b0;
                stateNext   = IDLE;
            end
            ERR: begin
                errorNext   = 1'b1;
                doneNext    = 1'b0;
                progEnNext  = 1'b0;
                cpuHoldNext = 1'b1;
                stateNext   = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            byteCnt    <= '0;
            byteTarget <= '0;
            lenReg     <= '0;
            csum       <= '0;
            idleCnt    <= '0;
            drainCnt   <= 1'b0;
            progEn     <= 1'b0;
            progData   <= '0;
            progValid  <= 1'b0;
            cpuHold    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            errCode    <= 2'd0;
        end else begin
            state      <= stateNext;
            byteCnt    <= byteCntNext;
            byteTarget <= byteTargetNext;
            lenReg     <= lenRegNext;
            csum       <= csumNext;
            idleCnt    <= idleCntNext;
            drainCnt   <= drainCntNext;
            progEn     <= progEnNext;
            progData   <= progDataNext;
            progValid  <= progValidNext;
            cpuHold    <= cpuHoldNext;
            busy       <= busyNext;
            done       <= doneNext;
            error      <= errorNext;
            errCode    <= errCodeNext;
        end
    end

    // Drive the interface from the output registers.
    always_comb begin
        bus.progEn    = progEn;
        bus.progData  = progData;
        bus.progValid = progValid;
        bus.cpuHold   = cpuHold;
        bus.busy      = busy;
        bus.done      = done;
        bus.error     = error;
        bus.errCode   = errCode;
    end
endmodule

// File: tb/tb_reprog_session_ctrl.sv
// Directed bench for reprog_session_ctrl (ADDR_WIDTH=2, TIMEOUT=50).
module tb_reprog_session_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pvNoEn = 0;
    int   cnt;
    logic [7:0] seen[$];
    logic [7:0] fr[$];

    always #5 clk = ~clk;

    reprog_session_ctrl_if bus ();

    reprog_session_ctrl #(
        .ADDR_WIDTH(2),
        .TIMEOUT   (50),
        .SYNC0     (8'h55),
        .SYNC1     (8'hAA)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    // Capture every forwarded payload byte.
    always @(negedge clk) begin
        if (bus.progValid) begin
            seen.push_back(bus.progData);
            if (!bus.progEn) pvNoEn++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus.rxData  = b;
        bus.rxValid = 1'b1;
        @(negedge clk);
        bus.rxValid = 1'b0;
    endtask

    task automatic sendFr();
        foreach (fr[i]) sendByte(fr[i]);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic goodFrame();
        fr = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        sendFr();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rxData  = 8'h00;
        bus.rxValid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_progEn",  32'(bus.progEn),    32'd0);
        chk("rst_pv",      32'(bus.progValid), 32'd0);
        chk("rst_hold",    32'(bus.cpuHold),   32'd0);
        chk("rst_busy",    32'(bus.busy),      32'd0);
        chk("rst_status",  32'({bus.done, bus.error, bus.errCode}), 32'd0);
        rstn = 1'b1;

        // Good frame, with progEn/cpuHold checked right after sync.
        seen.delete();
        sendByte(8'h55);
        sendByte(8'hAA);
        chk("len_progEn", 32'(bus.progEn),  32'd1);
        chk("len_hold",   32'(bus.cpuHold), 32'd1);
        chk("len_busy",   32'(bus.busy),    32'd1);
        fr = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        sendFr();
        chk("data_progEn", 32'(bus.progEn), 32'd1);
        sendByte(8'h64);
        waitIdle("good_idle");
        chk("good_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < seen.size()) chk($sformatf("good_byte%0d", i), 32'(seen[i]), 32'(8'h11 * (i + 1)));
        end
        chk("good_done",   32'(bus.done),    32'd1);
        chk("good_error",  32'(bus.error),   32'd0);
        chk("good_hold",   32'(bus.cpuHold), 32'd0);
        chk("good_progEn", 32'(bus.progEn),  32'd0);

        // Bad checksum.
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        sendFr();
        waitIdle("bad_idle");
        chk("bad_error",   32'(bus.error),   32'd1);
        chk("bad_code",    32'(bus.errCode), 32'd1);
        chk("bad_done",    32'(bus.done),    32'd0);
        chk("bad_hold",    32'(bus.cpuHold), 32'd1);
        chk("bad_progEn",  32'(bus.progEn),  32'd0);

        // Good frame clears the error.
        goodFrame();
        waitIdle("rec_idle");
        chk("rec_done",  32'(bus.done),    32'd1);
        chk("rec_error", 32'(bus.error),   32'd0);
        chk("rec_code",  32'(bus.errCode), 32'd0);
        chk("rec_hold",  32'(bus.cpuHold), 32'd0);

        // Count 5 exceeds 4 words.
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h05, 8'h00, 8'h00, 8'h00};
        sendFr();
        waitIdle("len5_idle");
        chk("len5_error", 32'(bus.error),   32'd1);
        chk("len5_code",  32'(bus.errCode), 32'd2);
        chk("len5_pv",    32'(seen.size()), 32'd0);
        chk("len5_hold",  32'(bus.cpuHold), 32'd1);

        // Count 4 is the maximum: bytes 01..10, sum 0x88.
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h04, 8'h00, 8'h00, 8'h00};
        for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
        fr.push_back(8'h88);
        sendFr();
        waitIdle("len4_idle");
        chk("len4_count", 32'(seen.size()), 32'd16);
        if (seen.size() == 16) begin
            chk("len4_first", 32'(seen[0]),  32'h01);
            chk("len4_last",  32'(seen[15]), 32'h10);
        end
        chk("len4_done",  32'(bus.done),  32'd1);
        chk("len4_error", 32'(bus.error), 32'd0);

        // Stall after three payload bytes.
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        sendFr();
        cnt = 0;
        while (!bus.error && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("to_cycles", 32'(cnt),         32'd52);
        chk("to_code",   32'(bus.errCode), 32'd3);
        chk("to_progEn", 32'(bus.progEn),  32'd0);
        chk("to_count",  32'(seen.size()), 32'd3);
        waitIdle("to_idle");

        // Repeated SYNC0 then zero-length frame.
        seen.delete();
        fr = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFr();
        waitIdle("zero_idle");
        chk("zero_done",  32'(bus.done),    32'd1);
        chk("zero_error", 32'(bus.error),   32'd0);
        chk("zero_pv",    32'(seen.size()), 32'd0);
        chk("zero_hold",  32'(bus.cpuHold), 32'd0);

        // Reset in the middle of the payload.
        fr = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        sendFr();
        chk("pre_rst_hold", 32'(bus.cpuHold), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_en",     32'({bus.progEn, bus.progValid, bus.cpuHold, bus.busy}), 32'd0);
        chk("mid_rst_status", 32'({bus.done, bus.error, bus.errCode}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen.delete();
        goodFrame();
        waitIdle("post_idle");
        chk("post_count", 32'(seen.size()), 32'd8);
        if (seen.size() > 0) chk("post_first", 32'(seen[0]), 32'h11);
        chk("post_done",  32'(bus.done), 32'd1);

        chk("pv_outside_en", 32'(pvNoEn), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
